// File: rtl/dsp_mac_sequencer.sv
// Sequences one DSP slice as a multiply-accumulate engine: streams N operand
// pairs into A/B, steers OPMODE/CEP from a tag pipe and returns the 48-bit sum.
// Optional pre-adder mode (sum of A*(D+/-B)) is enabled by `define DSP_SEQ_PREADD_EN.
module dsp_mac_sequencer #(
  parameter int MULT_LAT = 3,
  parameter int LEN_W    = 10
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
`ifdef DSP_SEQ_PREADD_EN
  input  logic [17:0]      in_d,
  input  logic             sub_en,
  output logic [17:0]      dsp_d,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_cea,
  output logic             dsp_ceb,
  output logic             dsp_cem,
  output logic             dsp_cep,
  output logic             dsp_rstp,
  input  logic [47:0]      dsp_p
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t              state, state_nxt;
  logic [LEN_W-1:0]    len_q, count;
  logic [MULT_LAT-1:0] tag_v, tag_f;
  logic [3:0]          opmode_xz;
  logic                accept, beat, drained;

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    accept    = 1'b0;
    beat      = 1'b0;
    drained   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        in_ready = (count < len_q);
        beat     = in_valid && in_ready;
        if (beat && ((count + LEN_W'(1)) == len_q)) state_nxt = DRAIN;
      end
      DRAIN: begin
        // P is final once no tag is in flight and no P update is pending.
        if ((tag_v == '0) && !dsp_cep) begin
          drained   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign dsp_cea = busy;
  assign dsp_ceb = busy;
  assign dsp_cem = busy;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      len_q     <= '0;
      count     <= '0;
      tag_v     <= '0;
      tag_f     <= '0;
      opmode_xz <= '0;
      dsp_cep   <= 1'b0;
      dsp_rstp  <= 1'b0;
      dsp_a     <= '0;
      dsp_b     <= '0;
      res_data  <= '0;
    end else begin
      dsp_rstp <= accept && (len != '0);
      if (accept) begin
        len_q <= len;
        count <= '0;
      end else if (beat) begin
        count <= count + LEN_W'(1);
      end
      dsp_a <= beat ? in_a : '0;
      dsp_b <= beat ? in_b : '0;
      // Tag stage 0 lines up with the dsp_a/dsp_b register; the last stage
      // feeds the registered post-adder controls.
      tag_v[0] <= beat;
      tag_f[0] <= beat && (count == '0);
      for (int unsigned i = 1; i < MULT_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_f[i] <= tag_f[i-1];
      end
      dsp_cep <= tag_v[MULT_LAT-1];
      if (!tag_v[MULT_LAT-1])     opmode_xz <= 4'b0000;
      else if (tag_f[MULT_LAT-1]) opmode_xz <= 4'b0001;
      else                        opmode_xz <= 4'b1001;
      if (accept && (len == '0)) res_data <= '0;
      else if (drained)          res_data <= dsp_p;
    end
  end

`ifdef DSP_SEQ_PREADD_EN
  logic [2:0] opmode_hi;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      opmode_hi <= '0;
      dsp_d     <= '0;
    end else begin
      if (accept) opmode_hi <= {sub_en, 1'b0, 1'b1};
      dsp_d <= beat ? in_d : '0;
    end
  end

  assign dsp_opmode = {1'b0, opmode_hi, opmode_xz};
`else
  assign dsp_opmode = {4'b0000, opmode_xz};
`endif

endmodule
